// File: rtl/alu_vector_checker.sv
// Purpose: self-check engine that streams {a, b, sel, exp} vectors through an ALU and counts pass/fail (optional ALU_CHK_MASK_EN adds a per-vector compare mask).
// Latency: vector accepted at edge N is compared and counted at edge N+1; done/all_pass are registered one edge after the last accept.
// Backpressure: vec_ready is high in IDLE/RUN and low in DRAIN/DONE and while clear is asserted; one vector per cycle in RUN.

// Combinational ALU exercised by the checker.
// Select map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 sll, 7 srl, 8 sra,
// 9 slt (signed), A sltu, B pass a, C pass b, D nand, E xnor, F zero.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       alu_select,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SH_W-1:0] sh_amt;
  logic            lt_signed;
  logic            lt_unsigned;

  assign sh_amt      = in_b[SH_W-1:0];
  assign lt_signed   = $signed(in_a) < $signed(in_b);
  assign lt_unsigned = in_a < in_b;

  // Decode the select code into the operation result.
  always_comb begin
    result = '0;
    case (alu_select)
      4'h0: result = in_a + in_b;
      4'h1: result = in_a - in_b;
      4'h2: result = in_a & in_b;
      4'h3: result = in_a | in_b;
      4'h4: result = in_a ^ in_b;
      4'h5: result = ~(in_a | in_b);
      4'h6: result = in_a << sh_amt;
      4'h7: result = in_a >> sh_amt;
      4'h8: result = $unsigned($signed(in_a) >>> sh_amt);
      4'h9: result = {{(WIDTH-1){1'b0}}, lt_signed};
      4'hA: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      4'hB: result = in_a;
      4'hC: result = in_b;
      4'hD: result = ~(in_a & in_b);
      4'hE: result = ~(in_a ^ in_b);
      default: result = '0;
    endcase
  end

endmodule

module alu_vector_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [3:0]       vec_sel,
  input  logic [WIDTH-1:0] vec_exp,
  input  logic             vec_last,
`ifdef ALU_CHK_MASK_EN
  input  logic [WIDTH-1:0] vec_mask,
`endif
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic             done,
  output logic             all_pass,
  output logic             fail_valid,
  output logic [CNT_W-1:0] fail_index,
  output logic [3:0]       fail_sel,
  output logic [WIDTH-1:0] fail_expected,
  output logic [WIDTH-1:0] fail_actual
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Stage 1: the vector currently presented to the ALU.
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_sel;
  logic [WIDTH-1:0] s1_exp;
  logic             s1_last;
  logic [WIDTH-1:0] cmp_mask;

  logic [WIDTH-1:0] alu_result;
  logic             accept;
  logic             match;
  logic             capture;

  logic [CNT_W-1:0] total_next;
  logic [CNT_W-1:0] pass_next;
  logic [CNT_W-1:0] fail_next;
  logic             done_next;
  logic             all_pass_next;

  // Ready only in the accepting states, and never while a clear is pending so
  // a same-cycle handshake cannot slip past the clear.
  assign vec_ready = !clear && ((state == ST_IDLE) || (state == ST_RUN));
  assign accept    = vec_valid && vec_ready;

  alu #(.WIDTH(WIDTH)) u_alu (
    .in_a       (s1_a),
    .in_b       (s1_b),
    .alu_select (s1_sel),
    .result     (alu_result)
  );

`ifdef ALU_CHK_MASK_EN
  logic [WIDTH-1:0] s1_mask;
  assign cmp_mask = s1_mask;

  // Mask travels with its vector through stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mask <= '0;
    end else if (!clear && accept) begin
      s1_mask <= vec_mask;
    end
  end
`else
  assign cmp_mask = '1;
`endif

  // Bits outside the mask are ignored; an all-zero mask always matches.
  assign match   = ((alu_result ^ s1_exp) & cmp_mask) == '0;
  assign capture = s1_vld && !match && !fail_valid;

  // Saturating next values for the counters on a compare edge.
  always_comb begin
    total_next = total_cnt;
    pass_next  = pass_cnt;
    fail_next  = fail_cnt;
    if (s1_vld) begin
      if (total_cnt != '1) total_next = total_cnt + 1'b1;
      if (match) begin
        if (pass_cnt != '1) pass_next = pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_next = fail_cnt + 1'b1;
      end
    end
  end

  // Run-control next state; clear overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = vec_last ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (accept && vec_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Nothing is accepted here, so stage 1 retires its final vector on
        // this edge and is empty afterwards.
        if (!s1_vld || s1_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  // Status flags are computed from the post-edge counts so they line up with
  // the final count landing.
  assign done_next     = (state_next == ST_DONE);
  assign all_pass_next = done_next && (fail_next == '0) && (total_next != '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage 1 load on accept; it empties on any edge without a new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_sel  <= '0;
      s1_exp  <= '0;
      s1_last <= 1'b0;
    end else if (clear) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a    <= vec_a;
        s1_b    <= vec_b;
        s1_sel  <= vec_sel;
        s1_exp  <= vec_exp;
        s1_last <= vec_last;
      end
    end
  end

  // Counters and run status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      done      <= 1'b0;
      all_pass  <= 1'b0;
    end else if (clear) begin
      total_cnt <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      done      <= 1'b0;
      all_pass  <= 1'b0;
    end else begin
      total_cnt <= total_next;
      pass_cnt  <= pass_next;
      fail_cnt  <= fail_next;
      done      <= done_next;
      all_pass  <= all_pass_next;
    end
  end

  // First-failure record; sticky until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid    <= 1'b0;
      fail_index    <= '0;
      fail_sel      <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (clear) begin
      fail_valid    <= 1'b0;
      fail_index    <= '0;
      fail_sel      <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (capture) begin
      fail_valid    <= 1'b1;
      fail_index    <= total_cnt;
      fail_sel      <= s1_sel;
      fail_expected <= s1_exp;
      fail_actual   <= alu_result;
    end
  end

endmodule
